window_3x3_gen: RTL and testbench
=================================

// Module: window_3x3_gen
// PURPOSE
//  Pixel-stream consumer for the frame-timing stage. It takes the raster pixel stream qualified by
//  valid/hStart/hEnd/vStart/vEnd and buffers the two previous rows in line buffers.
//  For each fully-interior pixel position it emits a registered 3x3 neighbourhood window.
//  It feeds the downstream convolution/filter kernels. No border padding: only (VMAX-2)*(HMAX-2) windows per frame.
// PARAMETERS
//  DW    8  pixel data width (bits)
//  HMAX  9  pixels per row (>=3)
//  VMAX  9  rows per frame (>=3)
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  pix_valid     in   1      pixel qualifier; pixel accepted on any clk edge where high
//  pix_hStart    in   1      first pixel of row (sampled only with pix_valid)
//  pix_hEnd      in   1      last pixel of row (sampled only with pix_valid)
//  pix_vStart    in   1      first pixel of frame (sampled only with pix_valid)
//  pix_vEnd      in   1      last pixel of frame (sampled only with pix_valid)
//  pix_data      in   DW     pixel value
//  win_data      out  9*DW   window; element (i,j) at bits [(3*i+j)*DW +: DW]; i=row 0=oldest, j=col 0=leftmost
//  win_valid     out  1      win_data/win_row/win_col valid this cycle (1-cycle pulse per window)
//  win_row       out  clog2(VMAX)  row index of window centre
//  win_col       out  clog2(HMAX)  column index of window centre
//  win_frame_end out  1      asserted with the last window of a frame (centre VMAX-2,HMAX-2)
//  sync_err      out  1      sticky: flag/position mismatch detected; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; col/row counters 0; line-buffer RAM contents are not cleared (don't-care).
//  Position tracking: counters (r,c) give the position of the next accepted pixel.
//  - Each accepted pixel advances c. At c=HMAX-1, c wraps to 0 and r increments.
//  - At (VMAX-1,HMAX-1), both counters wrap to (0,0).
//  - pix_valid low: counters, buffers and window regs all hold; win_valid=0.
//  vStart resync: an accepted pixel with pix_vStart=1 is treated as position (0,0), regardless of the counters.
//  - Counters then continue from (0,1).
//  - If the counters were not (0,0), sync_err <= 1.
//  Checks, each setting sync_err <= 1:
//  - pix_hStart with c!=0
//  - pix_hEnd with c!=HMAX-1
//  - pix_vEnd with (r,c)!=(VMAX-1,HMAX-1)
//  Apart from vStart, the flags never modify the counters.
//  Datapath per accepted pixel at (r,c):
//  - Read lb2[c] (row r-2) and lb1[c] (row r-1). Write lb2[c]<=lb1[c] and lb1[c]<=pix_data.
//  - Shift the window left by one column.
//  - New right column (j=2) = {i0:lb2[c], i1:lb1[c], i2:pix_data}.
//  Output timing:
//  - win_valid=1 on the edge after accepting a pixel with r>=2 && c>=2. Fixed latency 1 cycle.
//  - With that pulse: win_row=r-1, win_col=c-1, win_frame_end=(r==VMAX-1 && c==HMAX-1).
//  - win_data holds its value between pulses.
//  Row wrap: window columns carried over from the previous row are flushed by construction.
//  - No window is emitted for c<2, so stale left columns are never presented.
//  Mid-frame resync: a window is emitted only after two complete rows of the new frame are rewritten.
//  - This follows from the r>=2 rule.
//  - Stale line-buffer data therefore never appears in a valid window.
//  Back-to-back frames: no bubble is required; a vStart pixel may immediately follow a vEnd pixel.
//  Reset mid-frame: the block returns to reset state on the next edge. Any window in flight is dropped (win_valid=0).
//  Line buffers: 2 x HMAX x DW, inferred as registers or RAM.
//  - Read-before-write on the same index in the same cycle is required.
// TESTING
//  Pixel value convention: (r,c) has value r*9+c; HMAX=VMAX=9, continuous valid.
//  1 One 9x9 frame, values as above
//    -> 49 win_valid pulses.
//    -> First pulse: centre (1,1), win_data = {0,1,2, 9,10,11, 18,19,20}.
//    -> Last pulse: centre (7,7), win_frame_end=1.
//    -> sync_err stays 0.
//  2 Same frame with random pix_valid gaps (~40% low)
//    -> identical window sequence and values to test 1.
//    -> win_valid only on the edge following an accepted pixel.
//  3 Two frames back-to-back, frame 2 values +100
//    -> 98 windows total.
//    -> Frame-2 first window: centre (1,1), element (0,0)=100.
//    -> No frame-1 data in any frame-2 window.
//  4 pix_vStart asserted at position (3,4) mid-frame
//    -> sync_err=1 (sticky).
//    -> Next window: centre (1,1), built only from post-resync pixels.
//  5 pix_hEnd asserted at c=5 -> sync_err=1; counters unaffected; window values still follow counter positions.
//  6 reset pulsed for 1 cycle after 40 pixels, then a full clean frame
//    -> all outputs 0 during reset.
//    -> Then 49 correct windows, sync_err=0.

Source files
------------

// File: rtl/window_3x3_gen.sv
// ============================================================================
// window_3x3_gen : raster stream to 3x3 interior neighbourhood window
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module window_3x3_gen #(
  parameter int DW   = 8,
  parameter int HMAX = 9,
  parameter int VMAX = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pix_valid,
  input  logic                     pix_hStart,
  input  logic                     pix_hEnd,
  input  logic                     pix_vStart,
  input  logic                     pix_vEnd,
  input  logic [DW-1:0]            pix_data,
  output logic [9*DW-1:0]          win_data,
  output logic                     win_valid,
  output logic [$clog2(VMAX)-1:0]  win_row,
  output logic [$clog2(HMAX)-1:0]  win_col,
  output logic                     win_frame_end,
  output logic                     sync_err
);

  localparam int RW = $clog2(VMAX);
  localparam int CW = $clog2(HMAX);

  localparam logic [RW-1:0] c_ROW_LAST = RW'(VMAX - 1);
  localparam logic [CW-1:0] c_COL_LAST = CW'(HMAX - 1);
  localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] c_ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] c_COL_ONE  = CW'(1);

  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [9*DW-1:0] r_win;
  logic [DW-1:0]   r_lb1 [HMAX];
  logic [DW-1:0]   r_lb2 [HMAX];

  logic [RW-1:0]   w_effRow;
  logic [CW-1:0]   w_effCol;
  logic [RW-1:0]   w_nextRow;
  logic [CW-1:0]   w_nextCol;
  logic            w_isLast;
  logic            w_emit;
  logic            w_errNow;
  logic [DW-1:0]   w_lb1Rd;
  logic [DW-1:0]   w_lb2Rd;
  logic [9*DW-1:0] w_winNext;

  // A vStart pixel is position (0,0) no matter where the counters are.
  assign w_effRow = pix_vStart ? '0 : r_row;
  assign w_effCol = pix_vStart ? '0 : r_col;
  assign w_isLast = (w_effRow == c_ROW_LAST) && (w_effCol == c_COL_LAST);
  assign w_emit   = (w_effRow >= c_ROW_TWO) && (w_effCol >= c_COL_TWO);

  always_comb begin
    w_nextCol = w_effCol + c_COL_ONE;
    w_nextRow = w_effRow;
    if (w_effCol == c_COL_LAST) begin
      w_nextCol = '0;
      w_nextRow = (w_effRow == c_ROW_LAST) ? '0 : (w_effRow + c_ROW_ONE);
    end
  end

  assign w_errNow = (pix_vStart && ((r_row != '0) || (r_col != '0)))
                 || (pix_hStart && (w_effCol != '0))
                 || (pix_hEnd   && (w_effCol != c_COL_LAST))
                 || (pix_vEnd   && !w_isLast);

  assign w_lb1Rd = r_lb1[w_effCol];
  assign w_lb2Rd = r_lb2[w_effCol];

  always_comb begin
    w_winNext = r_win;
    for (int i = 0; i < 3; i++) begin
      w_winNext[(3*i+0)*DW +: DW] = r_win[(3*i+1)*DW +: DW];
      w_winNext[(3*i+1)*DW +: DW] = r_win[(3*i+2)*DW +: DW];
    end
    w_winNext[2*DW +: DW] = w_lb2Rd;
    w_winNext[5*DW +: DW] = w_lb1Rd;
    w_winNext[8*DW +: DW] = pix_data;
  end

  // Line buffers carry no reset; stale content is never emitted (r>=2 rule).
  always_ff @(posedge clk) begin
    if (pix_valid && !reset) begin
      r_lb2[w_effCol] <= w_lb1Rd;
      r_lb1[w_effCol] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row         <= '0;
      r_col         <= '0;
      r_win         <= '0;
      win_data      <= '0;
      win_valid     <= 1'b0;
      win_row       <= '0;
      win_col       <= '0;
      win_frame_end <= 1'b0;
      sync_err      <= 1'b0;
    end else if (pix_valid) begin
      r_row         <= w_nextRow;
      r_col         <= w_nextCol;
      r_win         <= w_winNext;
      win_valid     <= w_emit;
      win_frame_end <= w_emit && w_isLast;
      if (w_errNow)
        sync_err <= 1'b1;
      // Output copy only moves on a pulse so win_data holds between windows.
      if (w_emit) begin
        win_data <= w_winNext;
        win_row  <= w_effRow - c_ROW_ONE;
        win_col  <= w_effCol - c_COL_ONE;
      end
    end else begin
      win_valid     <= 1'b0;
      win_frame_end <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
// ============================================================================
// tb_window_3x3_gen : random-stimulus bench with frame-image reference model
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_window_3x3_gen;

  localparam int DW   = 8;
  localparam int HMAX = 9;
  localparam int VMAX = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_valid, pix_hStart, pix_hEnd, pix_vStart, pix_vEnd;
  logic [DW-1:0] pix_data;
  logic [9*DW-1:0] win_data;
  logic          win_valid;
  logic [3:0]    win_row;
  logic [3:0]    win_col;
  logic          win_frame_end;
  logic          sync_err;

  window_3x3_gen #(.DW(DW), .HMAX(HMAX), .VMAX(VMAX)) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_hStart(pix_hStart), .pix_hEnd(pix_hEnd),
    .pix_vStart(pix_vStart), .pix_vEnd(pix_vEnd), .pix_data(pix_data),
    .win_data(win_data), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .win_frame_end(win_frame_end), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Reference: last value written at each frame position plus position/error state.
  logic [DW-1:0] img [VMAX][HMAX];
  int mr, mc;
  bit mserr;
  int nCompared, nMismatched, nPulses;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendPix(input logic [DW-1:0] val, input bit hs, input bit he,
                         input bit vs, input bit ve);
    int er, ec;
    bit expV;
    logic [9*DW-1:0] expWin;
    er = vs ? 0 : mr;
    ec = vs ? 0 : mc;
    if (vs && (mr != 0 || mc != 0)) mserr = 1;
    if (hs && ec != 0) mserr = 1;
    if (he && ec != HMAX-1) mserr = 1;
    if (ve && !(er == VMAX-1 && ec == HMAX-1)) mserr = 1;
    img[er][ec] = val;
    expV = (er >= 2) && (ec >= 2);
    expWin = '0;
    if (expV)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          expWin[(3*i+j)*DW +: DW] = img[er-2+i][ec-2+j];
    mr = er;
    mc = ec + 1;
    if (mc == HMAX) begin
      mc = 0;
      mr = er + 1;
      if (mr == VMAX) mr = 0;
    end
    @(negedge clk);
    pix_valid = 1; pix_data = val;
    pix_hStart = hs; pix_hEnd = he; pix_vStart = vs; pix_vEnd = ve;
    @(posedge clk);
    #1;
    pix_valid = 0;
    check("win_valid", win_valid, expV);
    if (win_valid) nPulses++;
    if (expV) begin
      check("win_row", win_row, er - 1);
      check("win_col", win_col, ec - 1);
      check("win_frame_end", win_frame_end, (er == VMAX-1 && ec == HMAX-1));
      check("win_data", win_data, expWin);
    end
    check("sync_err", sync_err, mserr);
  endtask

  task automatic idleCycle();
    @(negedge clk);
    pix_valid = 0;
    @(posedge clk);
    #1;
    check("idle_valid", win_valid, 0);
    check("idle_sync_err", sync_err, mserr);
  endtask

  task automatic sendFrame(input int offset, input int gapPct, input int errRow);
    for (int r = 0; r < VMAX; r++)
      for (int c = 0; c < HMAX; c++) begin
        for (int g = 0; g < 4 && $urandom_range(99) < gapPct; g++) idleCycle();
        sendPix(DW'(r*HMAX + c + offset), c == 0,
                (c == HMAX-1) || (r == errRow && c == 5),
                r == 0 && c == 0, r == VMAX-1 && c == HMAX-1);
      end
  endtask

  task automatic sendPart(input int offset, input int n);
    for (int k = 0; k < n; k++) begin
      int r, c;
      r = k / HMAX;
      c = k % HMAX;
      sendPix(DW'(r*HMAX + c + offset), c == 0, c == HMAX-1,
              r == 0 && c == 0, r == VMAX-1 && c == HMAX-1);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1; pix_valid = 0;
    @(posedge clk);
    #1;
    check("rst_win_valid", win_valid, 0);
    check("rst_win_data", win_data, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_frame_end", win_frame_end, 0);
    check("rst_sync_err", sync_err, 0);
    @(negedge clk);
    reset = 0;
    mr = 0; mc = 0; mserr = 0;
  endtask

  initial begin
    reset = 0; pix_valid = 0; pix_data = '0;
    pix_hStart = 0; pix_hEnd = 0; pix_vStart = 0; pix_vEnd = 0;
    nCompared = 0; nMismatched = 0;
    doReset();

    nPulses = 0;
    sendFrame(0, 0, -1);
    check("t1_pulses", nPulses, 49);

    nPulses = 0;
    sendFrame(0, 40, -1);
    check("t2_pulses", nPulses, 49);

    nPulses = 0;
    sendFrame(0, 0, -1);
    sendFrame(100, 0, -1);
    check("t3_pulses", nPulses, 98);

    doReset();
    nPulses = 0;
    sendPart(0, 3*HMAX + 4);
    sendFrame(150, 0, -1);
    check("t4_pulses", nPulses, 58);
    check("t4_sync_err", sync_err, 1);

    doReset();
    nPulses = 0;
    sendFrame(0, 0, 4);
    check("t5_pulses", nPulses, 49);
    check("t5_sync_err", sync_err, 1);

    doReset();
    sendPart(0, 40);
    doReset();
    nPulses = 0;
    sendFrame(0, 0, -1);
    check("t6_pulses", nPulses, 49);
    check("t6_sync_err", sync_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

`default_nettype wire
